pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Program-counter owner for the single-cycle datapath; consumer end of the jump-target path.
//   Holds PC and exports pc_region = (PC+4)[31:28] to the jump-address unit.
//   Takes back the finished jump target, or a branch offset, and selects next PC.
//   Drives a req/ack fetch handshake to instruction memory.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0.
//   MAX_WAIT  16             cycles in S_REQ without ack before timeout; legal range 1..255.
// PORTS
//   clk            in   1   rising-edge clock; single clock domain.
//   rst_n          in   1   asynchronous, active-low reset.
//   stall          in   1   hold current instruction; PC must not advance.
//   jump_en        in   1   take jump_addr as next PC.
//   jump_addr      in   32  jump target from the jump-address unit.
//   branch_en      in   1   take branch target as next PC.
//   branch_offset  in   32  sign-extended word offset.
//   imem_req       out  1   fetch request to instruction memory.
//   imem_addr      out  32  fetch address; equals pc.
//   imem_ack       in   1   memory has instruction for imem_addr this cycle.
//   instr_valid    out  1   fetched instruction is current.
//   pc             out  32  current PC.
//   pc_region      out  4   pc_plus4[31:28]; feeds jump-address unit.
//   misalign_err   out  1   sticky: redirect target had [1:0] != 0.
//   timeout_err    out  1   sticky: no imem_ack within MAX_WAIT cycles.
// BEHAVIOUR
//   Reset (rst_n=0, immediate, asynchronous):
//     pc=RESET_PC, imem_req=0, instr_valid=0, both errs=0, wait counter=0, state=S_BOOT.
//     imem_req drops in the same cycle reset asserts, even mid-fetch.
//   Combinational outputs:
//     pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//     pc_region = pc_plus4[31:28]; imem_addr = pc.
//   FSM states; all outputs registered except imem_addr and pc_region:
//     S_BOOT: imem_req=0; on the next clock -> S_REQ (one dead cycle after reset).
//     S_REQ: imem_req=1; counter increments each cycle.
//       imem_ack=1 -> S_VALID, counter cleared.
//       counter reaches MAX_WAIT with no ack -> S_HALT, timeout_err=1.
//     S_VALID: instr_valid=1, imem_req=0.
//       stall=1: stay; PC held; jump_en and branch_en ignored.
//       stall=0: load next PC, then -> S_REQ.
//     S_HALT: imem_req=0, instr_valid=0; PC frozen; left only by reset.
//   Next-PC priority, evaluated only in S_VALID with stall=0:
//     1. jump_en=1 -> jump_addr.
//     2. branch_en=1 -> pc_plus4 + (branch_offset<<2), mod 2^32, sign preserved.
//     3. otherwise -> pc_plus4.
//     jump_en and branch_en both 1 -> jump wins, no error.
//   Misaligned redirect: if the selected jump or branch target has [1:0] != 0:
//     PC is not updated, misalign_err=1, -> S_HALT.
//   jump_en, branch_en and imem_ack are don't-care outside their stated states.
//   An ack arriving in S_BOOT, S_VALID or S_HALT is dropped.
//   Latency: req assert to instr_valid = ack cycle + 1. Zero-wait memory: 2 cycles per instruction.
// TESTING
//   T1 reset: RESET_PC=0x0040_0000; ack always 1.
//      -> pc sequence 0x400000, 0x400004, 0x400008; instr_valid every 2nd cycle.
//   T2 jump: pc=0x1000_0010, jump_en=1, jump_addr=0x1234_5678 with [1:0]=0 (use 0x1234_5670).
//      -> next pc=0x1234_5670; pc_region was 4'h1 beforehand.
//   T3 branch: pc=0x100, branch_offset=32'hFFFF_FFFE.
//      -> pc=0x0FC (0x104 - 8); same setup with jump_en=1 also set -> jump wins.
//   T4 stall and wrap: pc=0xFFFF_FFFC; stall=1 for 3 cycles.
//      -> pc unchanged and instr_valid held; after release pc=0x0, pc_region=4'h0 before update.
//   T5 errors: jump_addr=0x0000_0102 -> misalign_err=1, S_HALT, pc frozen.
//      Separate run: ack withheld 16 cycles -> timeout_err=1, imem_req=0.
//   T6 reset mid-fetch: drop rst_n while imem_req=1.
//      -> imem_req=0 immediately; after release, one S_BOOT cycle, then fetch at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch handshake between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches via req/ack, selects next PC from jump, branch or
// sequential flow, and halts on misaligned redirects or fetch timeouts.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  jump_en,
  input  logic [31:0]           jump_addr,
  input  logic                  branch_en,
  input  logic [31:0]           branch_offset,
  pc_sequencer_if.master        imem,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  output logic [3:0]            pc_region,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_VALID,
    S_HALT
  } state_t;

  localparam logic [8:0] MAX_WAIT_C = MAX_WAIT[8:0];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  wait_q, wait_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        redirect;
  logic [8:0]  wait_inc;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + (branch_offset << 2);
  assign wait_inc      = {1'b0, wait_q} + 9'd1;

  // Jump outranks branch; both outrank sequential flow.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (jump_en) begin
      next_pc  = jump_addr;
      redirect = 1'b1;
    end else if (branch_en) begin
      next_pc  = branch_target;
      redirect = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_d     = wait_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_BOOT: begin
        wait_d  = 8'd0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem.imem_ack) begin
          wait_d  = 8'd0;
          state_d = S_VALID;
        end else if (wait_inc >= MAX_WAIT_C) begin
          wait_d    = wait_inc[7:0];
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      S_VALID: begin
        if (!stall) begin
          if (redirect && (next_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Handshake outputs are flopped from the state we are about to enter.
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      wait_q     <= 8'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_region      = pc_plus4[31:28];
  assign misalign_err   = misalign_q;
  assign timeout_err    = timeout_q;

endmodule
